// File: rtl/mem_access_unit_pkg.sv
// Shared op codes, FSM states and datamemory bus encodings
// for the load/store front-end.
package mem_access_unit_pkg;

   typedef enum logic [2:0] {
      OP_LB  = 3'b000,
      OP_LH  = 3'b001,
      OP_LW  = 3'b010,
      OP_SB  = 3'b011,
      OP_LBU = 3'b100,
      OP_LHU = 3'b101,
      OP_SH  = 3'b110,
      OP_SW  = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_RD_WAIT,
      S_WR,
      S_RESP
   } state_e;

   typedef struct packed {
      logic cs;
      logic wr_rd;
   } bus_t;

   localparam bus_t BUS_IDLE  = '{cs: 1'b0, wr_rd: 1'b0};
   localparam bus_t BUS_READ  = '{cs: 1'b0, wr_rd: 1'b1};
   localparam bus_t BUS_WRITE = '{cs: 1'b1, wr_rd: 1'b0};

   function automatic logic is_byte(op_e op);
      return op inside {OP_LB, OP_LBU, OP_SB};
   endfunction

   function automatic logic is_half(op_e op);
      return op inside {OP_LH, OP_LHU, OP_SH};
   endfunction

   function automatic logic is_word(op_e op);
      return op inside {OP_LW, OP_SW};
   endfunction

   function automatic logic is_signed(op_e op);
      return op inside {OP_LB, OP_LH};
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the MEM stage
// and the load/store front-end.
interface mem_access_unit_if #(
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [DATA_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/mem_access_unit_load_extract.sv
// Load lane select plus sign/zero extension of a
// little-endian memory word.
module load_extract
   import mem_access_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] word_i,
   input  logic [1:0]        off_i,
   input  op_e               op_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [7:0]  b;
   logic [15:0] h;
   logic        sx;

   assign b  = word_i[{off_i, 3'b000} +: 8];
   assign h  = word_i[{off_i[1], 4'b0000} +: 16];
   assign sx = is_signed(op_i);

   always_comb begin
      rdata_o = word_i;
      unique case (1'b1)
         is_byte(op_i):
            rdata_o = {{(DATA_W-8){sx & b[7]}}, b};
         is_half(op_i):
            rdata_o = {{(DATA_W-16){sx & h[15]}}, h};
         default: rdata_o = word_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end to a word-wide datamemory with RMW for SB/SH.
// Define MEM_ALIGN_TRAP_EN to report misaligned LH/LHU/SH/LW/SW.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_access_unit_if.slave  req,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_wr_rd,
   output logic              mem_cs,
   input  logic [DATA_W-1:0] mem_dout
);

   state_e            state_q;
   op_e               op_q;
   logic [1:0]        off_q;
   logic [15:0]       wdata_q;
   logic              req_ready_q;
   logic              resp_valid_q;
   logic              resp_err_q;
   logic [DATA_W-1:0] resp_rdata_q;
   logic [DATA_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_din_q;
   bus_t              bus_q;

   op_e               op_in;
   logic [DATA_W-3:0] widx;
   logic              oor;
   logic              align_err;
   logic              err_d;
   logic [1:0]        off_d;
   logic [DATA_W-1:0] ld_data;
   logic [DATA_W-1:0] wr_word;

   assign op_in = op_e'(req.req_op);
   assign widx  = req.req_addr[DATA_W-1:2];
   assign oor   = widx >= (DATA_W-2)'(MEM_DEPTH);

`ifdef MEM_ALIGN_TRAP_EN
   assign align_err = (is_half(op_in) & req.req_addr[0])
                    | (is_word(op_in) & (|req.req_addr[1:0]));
`else
   assign align_err = 1'b0;
`endif

   assign err_d = oor | align_err;

   // Misaligned low bits are dropped when they are not trapped.
   always_comb begin
      off_d = req.req_addr[1:0];
      unique case (1'b1)
         is_word(op_in): off_d = 2'b00;
         is_half(op_in): off_d = {req.req_addr[1], 1'b0};
         default:        off_d = req.req_addr[1:0];
      endcase
   end

   load_extract #(
      .DATA_W (DATA_W)
   ) u_extract (
      .word_i  (mem_dout),
      .off_i   (off_q),
      .op_i    (op_q),
      .rdata_o (ld_data)
   );

   always_comb begin
      wr_word = mem_dout;
      unique case (1'b1)
         op_q == OP_SB:
            wr_word[{off_q, 3'b000} +: 8] = wdata_q[7:0];
         op_q == OP_SH:
            wr_word[{off_q[1], 4'b0000} +: 16] = wdata_q;
         default: wr_word = mem_dout;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         op_q         <= OP_LB;
         off_q        <= 2'b00;
         wdata_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
         bus_q        <= BUS_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (req.req_valid) begin
                  op_q        <= op_in;
                  off_q       <= off_d;
                  wdata_q     <= req.req_wdata[15:0];
                  req_ready_q <= 1'b0;
                  if (err_d) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                  end else if (op_in == OP_SW) begin
                     state_q    <= S_WR;
                     mem_addr_q <= {2'b00, widx};
                     mem_din_q  <= req.req_wdata;
                     bus_q      <= BUS_WRITE;
                  end else begin
                     state_q    <= S_RD;
                     mem_addr_q <= {2'b00, widx};
                     bus_q      <= BUS_READ;
                  end
               end
            end
            S_RD: begin
               state_q <= S_RD_WAIT;
               bus_q   <= BUS_IDLE;
            end
            S_RD_WAIT: begin
               if (op_q inside {OP_SB, OP_SH}) begin
                  state_q   <= S_WR;
                  mem_din_q <= wr_word;
                  bus_q     <= BUS_WRITE;
               end else begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= ld_data;
               end
            end
            S_WR: begin
               state_q      <= S_RESP;
               bus_q        <= BUS_IDLE;
               resp_valid_q <= 1'b1;
               resp_rdata_q <= '0;
            end
            S_RESP: begin
               state_q      <= S_IDLE;
               req_ready_q  <= 1'b1;
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= '0;
            end
            default: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
               bus_q       <= BUS_IDLE;
            end
         endcase
      end
   end

   assign req.req_ready  = req_ready_q;
   assign req.resp_valid = resp_valid_q;
   assign req.resp_err   = resp_err_q;
   assign req.resp_rdata = resp_rdata_q;
   assign mem_addr       = mem_addr_q;
   assign mem_din        = mem_din_q;
   assign mem_cs         = bus_q.cs;
   assign mem_wr_rd      = bus_q.wr_rd;

endmodule
